crack_sched: RTL

Top-level scheduler for parallel ARC4 key search. It partitions the 24-bit key space across `NWORK` external `crack` workers using interleaved keys: worker i starts at key i and steps by NWORK. It launches all workers together and monitors their `rdy`/`key_valid` handshakes, selecting the first valid key by lowest worker index. It then copies the winning worker's length-prefixed plaintext out of that worker's `pt_mem` into a shared output memory.

---
 rtl/crack_sched_if.sv | 49 ++++
 rtl/crack_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/crack_sched_if.sv
// ============================================================================
//  Module      : crack_sched_if
//  Description : Bundles the signals between the crack_sched key-search
//                scheduler and its environment: host start/result
//                handshake, the per-worker launch/status/key lines, the
//                plaintext copy port shared by all workers and the output
//                memory write port.
//  Ports       : master modport - scheduler side (drives rdy, key, key_valid,
//                w_en, w_start_key, w_key_inc, w_pt_addr, w_pt_wren, out_*)
//                slave modport  - environment side (drives en, w_rdy,
//                w_key_valid, w_key, w_pt_rddata)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface crack_sched_if #(
    parameter int NWORK = 2
);
    logic                  en;
    logic                  rdy;
    logic [23:0]           key;
    logic                  key_valid;
    logic [NWORK-1:0]      w_en;
    logic [NWORK-1:0]      w_rdy;
    logic [NWORK-1:0]      w_key_valid;
    logic [24*NWORK-1:0]   w_key;
    logic [24*NWORK-1:0]   w_start_key;
    logic [23:0]           w_key_inc;
    logic [7:0]            w_pt_addr;
    logic                  w_pt_wren;
    logic [8*NWORK-1:0]    w_pt_rddata;
    logic [7:0]            out_addr;
    logic [7:0]            out_wrdata;
    logic                  out_wren;

    modport master (
        input  en, w_rdy, w_key_valid, w_key, w_pt_rddata,
        output rdy, key, key_valid, w_en, w_start_key, w_key_inc,
               w_pt_addr, w_pt_wren, out_addr, out_wrdata, out_wren
    );

    modport slave (
        output en, w_rdy, w_key_valid, w_key, w_pt_rddata,
        input  rdy, key, key_valid, w_en, w_start_key, w_key_inc,
               w_pt_addr, w_pt_wren, out_addr, out_wrdata, out_wren
    );
endinterface

`default_nettype wire

// File: rtl/crack_sched.sv
// ============================================================================
//  Module      : crack_sched
//  Description : Scheduler for a parallel ARC4 key search. Worker i searches
//                keys i, i+NWORK, i+2*NWORK, ... All workers are launched
//                together; the first worker to report a valid key (lowest
//                index on a tie) wins, and its length-prefixed plaintext
//                pt[0..pt[0]] is copied into the shared output memory.
//  Ports       : clk, rst_n (synchronous, active-low)
//                bus (crack_sched_if.master):
//                  en/rdy          host start handshake
//                  key/key_valid   search result
//                  w_en/w_rdy/w_key_valid/w_key  worker control and status
//                  w_start_key/w_key_inc         constant key partitioning
//                  w_pt_addr/w_pt_wren/w_pt_rddata  worker plaintext read
//                  out_addr/out_wrdata/out_wren     output memory write
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crack_sched #(
    parameter int NWORK = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    crack_sched_if.master   bus
);

    localparam logic [23:0] c_key_none = 24'hFFFFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_ARM    = 3'd2,
        S_WAIT   = 3'd3,
        S_COPY   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_launch;

    logic [23:0]        r_key;
    logic               r_key_valid;
    logic [3:0]         r_win;
    logic [7:0]         r_addr;
    logic [7:0]         r_len;
    logic [7:0]         r_out_addr;
    logic               r_out_wren;

    logic [NWORK-1:0]   w_hit;
    logic               w_any_hit;
    logic               w_all_done;
    logic [3:0]         w_win_idx;
    logic [23:0]        w_win_key;
    logic [7:0]         w_rd;
    logic [7:0]         w_len;
    logic               w_last;

    // ------------------------------------------------------------------
    // Worker status decode: a worker is done when its rdy is high; the
    // winner is the lowest-indexed done worker holding a valid key.
    // Scanning downward lets the lowest index overwrite higher ones.
    // ------------------------------------------------------------------
    always_comb begin
        w_hit      = bus.w_rdy & bus.w_key_valid;
        w_any_hit  = |w_hit;
        w_all_done = &bus.w_rdy;
        w_win_idx  = '0;
        w_win_key  = '0;
        for (int i = NWORK - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_win_idx = 4'(i);
                w_win_key = bus.w_key[24*i +: 24];
            end
        end
    end

    // Read-data mux from the latched winner's plaintext port.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NWORK; i++) begin
            if (r_win == 4'(i)) begin
                w_rd = bus.w_pt_rddata[8*i +: 8];
            end
        end
    end

    // The length byte arrives with the write to address 0, so it is taken
    // straight from the read port on that cycle and from r_len afterwards.
    // This lets an L=0 copy terminate after its single write.
    assign w_len  = (r_out_addr == 8'd0) ? w_rd : r_len;
    assign w_last = r_out_wren && (r_out_addr == w_len);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.en) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (w_all_done) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_ARM;
                end
            end
            // Workers only drop rdy the cycle after their start pulse, so
            // w_rdy is not trusted on this cycle.
            S_ARM: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_any_hit) begin
                    w_state_nxt = S_COPY;
                end else if (w_all_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COPY: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result and copy datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_win       <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_out_addr  <= '0;
            r_out_wren  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.en) begin
                        r_key_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_any_hit) begin
                        r_key <= w_win_key;
                        r_win <= w_win_idx;
                    end else if (w_all_done) begin
                        r_key       <= c_key_none;
                        r_key_valid <= 1'b0;
                    end
                end
                S_COPY: begin
                    if (r_out_wren && (r_out_addr == 8'd0)) begin
                        r_len <= w_rd;
                    end
                    // The write register trails the read address by one
                    // cycle; completion is decided on the write side so the
                    // 8-bit read counter may roll over after address 255
                    // without affecting the final write.
                    if (w_last) begin
                        r_out_wren  <= 1'b0;
                        r_out_addr  <= '0;
                        r_addr      <= '0;
                        r_key_valid <= 1'b1;
                    end else begin
                        r_out_wren  <= 1'b1;
                        r_out_addr  <= r_addr;
                        r_addr      <= r_addr + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rdy        = (r_state == S_IDLE);
    assign bus.key        = r_key;
    assign bus.key_valid  = r_key_valid;
    assign bus.w_en       = {NWORK{w_launch}};
    assign bus.w_key_inc  = 24'(NWORK);
    assign bus.w_pt_addr  = r_addr;
    assign bus.w_pt_wren  = 1'b0;
    assign bus.out_addr   = r_out_addr;
    // Write data is the worker's registered read port, passed through while
    // a write is in flight and held at zero otherwise.
    assign bus.out_wrdata = r_out_wren ? w_rd : 8'h00;
    assign bus.out_wren   = r_out_wren;

    for (genvar gi = 0; gi < NWORK; gi++) begin : g_start_key
        assign bus.w_start_key[24*gi +: 24] = 24'(gi);
    end

endmodule

`default_nettype wire
